// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the buffered UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Word-push handshake between a producer and the UART transmit FIFO.
interface uart_tx_buffered_if #(
    parameter int DATA_BITS = 8
);
    // A word transfers on a rising clock edge where in_valid && in_ready; the producer
    // holds in_data stable while in_valid is high, and in_ready never depends on in_valid.
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is read combinationally.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: LSB-first frames with optional parity and 1/2 stop bits,
// back-to-back frames when more words are queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_tx_buffered_if.slave             in_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output uart_state_t                   fsm_state
);
    localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int DIV_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             ODD_INV   = (PARITY == PARITY_ODD);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data_bits
        $error("uart_tx_buffered: DATA_BITS must be in 5..8");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_chk_parity
        $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop_bits
        $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo_depth
        $error("uart_tx_buffered: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (CLOCKS_PER_BIT < 2) begin : g_chk_clocks_per_bit
        $error("uart_tx_buffered: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end

    uart_state_t          state, state_n;
    logic [DIV_W-1:0]     div, div_n;
    logic [2:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_acc, par_n;
    logic                 tx_n;
    logic                 pop;
    logic                 bit_done;
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (in_if.in_valid),
        .wr_data (in_if.in_data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_if.in_ready = !fifo_full;
    assign busy           = (state != UART_IDLE);
    assign fsm_state      = state;
    assign bit_done       = (div == DIV_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= UART_IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_acc <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            div     <= div_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            par_acc <= par_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par_acc;
        tx_n    = tx;
        pop     = 1'b0;
        // Divider only runs inside a frame and wraps at each bit boundary.
        if (state != UART_IDLE) div_n = bit_done ? '0 : div + 1'b1;
        case (state)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_rd;
                    par_n   = 1'b0;
                    tx_n    = 1'b0;
                    div_n   = '0;
                    state_n = UART_START;
                end
            end
            UART_START: begin
                if (bit_done) begin
                    tx_n    = shift[0];
                    bit_n   = '0;
                    state_n = UART_DATA;
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    par_n   = par_acc ^ shift[0];
                    shift_n = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        if (PARITY != PARITY_NONE) begin
                            tx_n    = par_n ^ ODD_INV;
                            state_n = UART_PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            bit_n   = '0;
                            state_n = UART_STOP;
                        end
                    end else begin
                        tx_n  = shift[1];
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            UART_PARITY: begin
                if (bit_done) begin
                    tx_n    = 1'b1;
                    bit_n   = '0;
                    state_n = UART_STOP;
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    if (bit_cnt != STOP_LAST) begin
                        bit_n = bit_cnt + 3'd1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next start bit so frames stay contiguous.
                        pop     = 1'b1;
                        shift_n = fifo_rd;
                        par_n   = 1'b0;
                        tx_n    = 1'b0;
                        state_n = UART_START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = UART_IDLE;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                div_n   = '0;
                state_n = UART_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four configurations (8N1, 8E1, 8O1, 7E2) checked every cycle
// against a frame-level line model, plus directed literal checks.
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int CPB  = 104;
    localparam int NDUT = 4;
    localparam int DB  [NDUT] = '{8, 8, 8, 7};
    localparam int PAR [NDUT] = '{0, 1, 2, 1};
    localparam int SB  [NDUT] = '{1, 1, 1, 2};

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [NDUT-1:0]      valid_v;
    logic [NDUT-1:0][7:0] data_v;
    logic [NDUT-1:0]      tx_v, busy_v, rdy_v;
    logic [NDUT-1:0][4:0] lvl_v;
    uart_state_t          st0, st1, st2, st3;

    uart_tx_buffered_if #(.DATA_BITS(8)) if0 ();
    uart_tx_buffered_if #(.DATA_BITS(8)) if1 ();
    uart_tx_buffered_if #(.DATA_BITS(8)) if2 ();
    uart_tx_buffered_if #(.DATA_BITS(7)) if3 ();

    assign if0.in_valid = valid_v[0];
    assign if1.in_valid = valid_v[1];
    assign if2.in_valid = valid_v[2];
    assign if3.in_valid = valid_v[3];
    assign if0.in_data  = data_v[0];
    assign if1.in_data  = data_v[1];
    assign if2.in_data  = data_v[2];
    assign if3.in_data  = data_v[3][6:0];
    assign rdy_v[0] = if0.in_ready;
    assign rdy_v[1] = if1.in_ready;
    assign rdy_v[2] = if2.in_ready;
    assign rdy_v[3] = if3.in_ready;

    uart_tx_buffered dut0 (.clock(clock), .reset(reset), .in_if(if0), .tx(tx_v[0]),
                           .busy(busy_v[0]), .fifo_level(lvl_v[0]), .fsm_state(st0));
    uart_tx_buffered #(.PARITY(1)) dut1 (.clock(clock), .reset(reset), .in_if(if1), .tx(tx_v[1]),
                           .busy(busy_v[1]), .fifo_level(lvl_v[1]), .fsm_state(st1));
    uart_tx_buffered #(.PARITY(2)) dut2 (.clock(clock), .reset(reset), .in_if(if2), .tx(tx_v[2]),
                           .busy(busy_v[2]), .fifo_level(lvl_v[2]), .fsm_state(st2));
    uart_tx_buffered #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut3 (.clock(clock), .reset(reset),
                           .in_if(if3), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_level(lvl_v[3]),
                           .fsm_state(st3));

    int checks = 0;
    int errors = 0;
    int acc_cyc [NDUT];

    task automatic check(input string name, input int i, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, i, got, exp, cyc);
        end
    endtask

    // Line model: FIFO contents as a queue, current frame as a bit list in line order.
    logic [7:0]  exp_q  [NDUT][$];
    logic [11:0] m_bits [NDUT];
    int          m_len  [NDUT];
    int          m_cyc  [NDUT];
    logic        m_act  [NDUT];

    function automatic logic [11:0] make_frame(input int i, input logic [7:0] w, output int nbits);
        logic [11:0] f;
        logic        p;
        int          k;
        f = '1;
        p = 1'b0;
        f[0] = 1'b0;
        k = 1;
        for (int b = 0; b < DB[i]; b++) begin
            f[k] = w[b];
            p = p ^ w[b];
            k++;
        end
        if (PAR[i] != 0) begin
            f[k] = (PAR[i] == 2) ? ~p : p;
            k++;
        end
        nbits = k + SB[i];
        return f;
    endfunction

    initial begin
        int         pre_n;
        logic       do_push;
        logic [7:0] w;
        int         nb;
        for (int i = 0; i < NDUT; i++) begin
            m_act[i] = 1'b0; m_cyc[i] = 0; m_len[i] = 0; m_bits[i] = '1;
        end
        forever begin
            @(posedge clock or negedge reset);
            for (int i = 0; i < NDUT; i++) begin
                if (!reset) begin
                    exp_q[i].delete();
                    m_act[i] = 1'b0;
                    m_cyc[i] = 0;
                end else begin
                    pre_n   = exp_q[i].size();
                    do_push = valid_v[i] && (pre_n < 16);
                    if (m_act[i]) begin
                        if (m_cyc[i] == m_len[i] - 1) m_act[i] = 1'b0;
                        else m_cyc[i]++;
                    end
                    if (!m_act[i] && pre_n > 0) begin
                        w = exp_q[i].pop_front();
                        m_bits[i] = make_frame(i, w, nb);
                        m_len[i]  = nb * CPB;
                        m_cyc[i]  = 0;
                        m_act[i]  = 1'b1;
                    end
                    if (do_push) exp_q[i].push_back(data_v[i]);
                end
            end
        end
    end

    // Compare process: every DUT output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < NDUT; i++) begin
                check("model_tx", i, int'(tx_v[i]),
                      m_act[i] ? int'(m_bits[i][m_cyc[i] / CPB]) : 1);
                check("model_busy", i, int'(busy_v[i]), int'(m_act[i]));
                check("model_level", i, int'(lvl_v[i]), exp_q[i].size());
                check("model_ready", i, int'(rdy_v[i]), (exp_q[i].size() < 16) ? 1 : 0);
            end
        end
    end

    // Driver: call away from the edge; returns #1 after the accepting edge.
    task automatic push(input int i, input logic [7:0] d, input int budget, output int waited);
        logic acc;
        waited = 0;
        data_v[i]  = d;
        valid_v[i] = 1'b1;
        forever begin
            acc = rdy_v[i];
            @(posedge clock);
            #1;
            if (acc) break;
            waited++;
            if (waited > budget) break;
        end
        valid_v[i] = 1'b0;
        acc_cyc[i] = cyc;
        check("push_accepted_in_budget", i, (waited <= budget) ? 1 : 0, 1);
    endtask

    // Called right after the pushing edge of a word into an idle, empty transmitter.
    task automatic measure(input int i, input logic [11:0] exp_f, input int exp_len);
        int t;
        t = 0;
        check("tx_high_at_push_edge", i, int'(tx_v[i]), 1);
        @(posedge clock);
        #1;
        check("start_bit_low", i, int'(tx_v[i]), 0);
        check("busy_rises_with_start", i, int'(busy_v[i]), 1);
        while (busy_v[i] && t < 3000) begin
            if (t % CPB == CPB / 2 && t / CPB < 12)
                check($sformatf("frame_bit%0d", t / CPB), i, int'(tx_v[i]), int'(exp_f[t / CPB]));
            @(posedge clock);
            #1;
            t++;
        end
        check("frame_busy_cycles", i, t, exp_len);
        check("idle_tx_high", i, int'(tx_v[i]), 1);
    endtask

    task automatic rand_traffic(input int i, input int nwords);
        int w;
        int gap;
        for (int k = 0; k < nwords; k++) begin
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 600);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            push(i, 8'($urandom_range(0, 255)), 20000, w);
        end
    endtask

    initial begin
        #(95000 * 10);
        errors++;
        $display("FAIL watchdog: simulation did not complete in time (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int w0, w1, w2, w3, n, a, c3;
        valid_v = '0;
        data_v  = '0;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("reset_tx", i, int'(tx_v[i]), 1);
            check("reset_busy", i, int'(busy_v[i]), 0);
            check("reset_level", i, int'(lvl_v[i]), 0);
            check("reset_ready", i, int'(rdy_v[i]), 1);
        end
        check("reset_state", 0, int'(st0), int'(UART_IDLE));
        check("reset_state", 1, int'(st1), int'(UART_IDLE));
        check("reset_state", 2, int'(st2), int'(UART_IDLE));
        check("reset_state", 3, int'(st3), int'(UART_IDLE));
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single frames: 8N1 0x55, 8E1 0x55, 8O1 0x55, 7E2 0x7F.
        fork
            begin push(0, 8'h55, 10, w0); measure(0, 12'h2AA, 1040); end
            begin push(1, 8'h55, 10, w1); measure(1, 12'h4AA, 1144); end
            begin push(2, 8'h55, 10, w2); measure(2, 12'h6AA, 1144); end
            begin push(3, 8'h7F, 10, w3); measure(3, 12'h7FE, 1144); end
        join
        repeat (5) @(posedge clock);
        #1;

        // Overfill while the line is busy: 1 in flight, 16 queued, the 17th waits for a pop.
        push(0, 8'hC3, 10, w0);
        c3 = acc_cyc[0];
        for (int k = 0; k < 16; k++) push(0, 8'($urandom_range(0, 255)), 10, w0);
        check("full_level", 0, int'(lvl_v[0]), 16);
        check("full_ready_low", 0, int'(rdy_v[0]), 0);
        push(0, 8'h3C, 3000, w0);
        check("held_push_waits_for_pop", 0, (w0 > 900) ? 1 : 0, 1);
        check("level_after_held_push", 0, int'(lvl_v[0]), 16);
        n = 0;
        while (busy_v[0] && n < 25000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("contiguous_18_frames", 0, cyc - c3 - 1, 18 * 1040);
        repeat (3) @(posedge clock);
        #1;

        // Push and pop on the same edge at level 5.
        push(0, 8'h11, 10, w0);
        a = acc_cyc[0];
        for (int k = 0; k < 5; k++) push(0, 8'($urandom_range(0, 255)), 10, w0);
        check("level_five", 0, int'(lvl_v[0]), 5);
        while (cyc < a + 1040) begin
            @(posedge clock);
            #1;
        end
        push(0, 8'h22, 10, w0);
        check("push_on_pop_edge", 0, acc_cyc[0], a + 1041);
        check("level_unchanged_push_pop", 0, int'(lvl_v[0]), 5);

        // Reset in the middle of the data bits with words queued.
        repeat (3 * CPB + 30) @(posedge clock);
        #1;
        check("pre_reset_busy", 0, int'(busy_v[0]), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_tx", 0, int'(tx_v[0]), 1);
        check("async_reset_busy", 0, int'(busy_v[0]), 0);
        check("async_reset_level", 0, int'(lvl_v[0]), 0);
        check("async_reset_ready", 0, int'(rdy_v[0]), 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        push(0, 8'hA3, 10, w0);
        measure(0, 12'h346, 1040);

        // Random traffic on all four configurations.
        fork
            rand_traffic(0, 10);
            rand_traffic(1, 10);
            rand_traffic(2, 10);
            rand_traffic(3, 10);
        join
        n = 0;
        while ((busy_v != '0 || lvl_v != '0) && n < 30000) begin
            @(posedge clock);
            #1;
            n++;
        end
        for (int i = 0; i < NDUT; i++) begin
            check("drained_busy", i, int'(busy_v[i]), 0);
            check("drained_level", i, int'(lvl_v[i]), 0);
        end
        repeat (5) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, FIFO-buffered UART transmitter for the sniffer's host-facing serial path. Callers push data words over a valid/ready handshake into an internal FIFO, and the block serialises them LSB-first onto `tx`. Data width, parity mode and stop-bit count are configurable. The bit period comes from a single-clock-domain baud divider, and there is no derived clock.

## Interface
- `CLOCK_FREQ`, default 12_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in baud. `CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE` uses integer division and must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd. Any other value is illegal.
- `STOP_BITS`, default 1: legal values are 1 or 2.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of 2 and ≥ 2.
- `clock`, in, 1: system clock, all logic on its rising edge. Already decided.
- `reset`, in, 1: asynchronous, active-low. Already decided.
- `in_data`, in, `DATA_BITS`: word to transmit.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: FIFO can accept a word. Combinational `!full`.
- `tx`, out, 1: serial line, registered, idles high.
- `busy`, out, 1: high while a frame is on the line (any state other than IDLE).
- `fifo_level`, out, `$clog2(FIFO_DEPTH)+1`: number of words currently stored.

## Operation
- A push occurs on a rising edge with `in_valid && in_ready`. While the FIFO is full, `in_ready` is 0 and `in_valid` is ignored; no word is dropped or overwritten.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE: `tx` = 1. If the FIFO is not empty, pop the head word into the shift register, clear the parity accumulator, set `tx` = 0 and enter START.
- START: after `CLOCKS_PER_BIT` cycles, drive data bit 0 and enter DATA.
- DATA: shift out bits LSB-first, one bit per `CLOCKS_PER_BIT` cycles, accumulating the XOR of the bits.
  - After bit `DATA_BITS-1`, go to PARITY if `PARITY` != 0, otherwise go to STOP.
- PARITY: the parity bit is the XOR of the data bits for even parity, and its inverse for odd parity.
- STOP: drive `tx` = 1 for `STOP_BITS × CLOCKS_PER_BIT` cycles.
  - On the last cycle of STOP, if the FIFO is not empty, pop and drive the next start bit directly, so the frames are contiguous with no idle gap.
  - Otherwise go to IDLE.
- The baud divider restarts at 0 on every bit boundary and on IDLE exit. It never free-runs in IDLE.
- Simultaneous push and pop: both take effect and `fifo_level` is unchanged. A push into an empty FIFO cannot be popped on the same edge.
- Asynchronous reset, including mid-frame: the frame is aborted and the FIFO is flushed. Reset values: `tx` = 1, `busy` = 0, `fifo_level` = 0, `in_ready` = 1, state = IDLE, divider = 0.

## Timing
- Latency: if a word is pushed at edge N into an empty FIFO while the FSM is IDLE, `tx` falls after edge N+1 (the pop occurs at N+1).
- Frame length is exactly `(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × CLOCKS_PER_BIT` cycles.
- Each bit is held for exactly `CLOCKS_PER_BIT` cycles with no jitter. The fractional baud error from integer division is accepted.
- `busy` rises on the same edge as the falling start bit. It falls on the edge `tx` enters IDLE, and stays high across back-to-back frames.
- `fifo_level` and `in_ready` reflect each push or pop on the edge after it occurs.
- Throughput: a full FIFO drains as `FIFO_DEPTH` contiguous frames.

## Structure
- Package `uart_pkg`:
  - constants `PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`;
  - the FSM state encoding (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`).
- Sub-module `uart_sync_fifo`, parameters WIDTH and DEPTH:
  - binary read/write pointers with an extra wrap bit, giving full/empty/level;
  - asynchronous active-low reset.
- The top level contains the baud divider, the FSM, the shift register, the bit counter and the parity accumulator.
- Elaboration-time checks reject illegal `DATA_BITS`, `PARITY`, `STOP_BITS`, `FIFO_DEPTH` and `CLOCKS_PER_BIT` < 2.

## Test plan
- Defaults (8N1, `CLOCKS_PER_BIT` = 104), push 0x55 → `tx` low after one cycle, then bits 1,0,1,0,1,0,1,0 each held 104 cycles, then 104 high. Frame = 1040 cycles; `busy` is high for exactly 1040 cycles.
- 8E1 push 0x55 → parity bit 0 and 1144-cycle frame. 8O1 push 0x55 → parity bit 1. 7E2 push 0x7F → parity bit 1, stop high for 208 cycles.
- Push 17 words with `FIFO_DEPTH` = 16 while the line is busy:
  - `in_ready` drops at `fifo_level` 16, and `in_valid` held is accepted only after the next pop;
  - all 17 words appear in order as contiguous frames with no idle cycles between them.
- Push and pop on the same edge at `fifo_level` 5 → `fifo_level` stays 5.
- Assert `reset` low mid-DATA of a frame with 3 words queued:
  - `tx` goes to 1 immediately; `busy` = 0, `fifo_level` = 0;
  - after release, a new push transmits cleanly with no remnant bits.
- Push while IDLE at edge N → start bit observed from edge N+1. A random-stimulus scoreboard decodes `tx` and matches the pushed words across parity and stop modes.
